set_count_gen: RTL

SET_COUNT_GEN -- requirements
Module: set_count_gen

---
 rtl/set_count_gen_if.sv | 23 ++
 rtl/set_count_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/set_count_gen_if.sv
// Handshake bundle for set_count_gen: job request/operands in, status/result out.
interface set_count_gen_if #(
  parameter int CW    = 4,
  parameter int CNT_W = 8
);
  logic             i_en;
  logic [4*CW-1:0]  i_central;
  logic [2*CW-1:0]  i_radius;
  logic [1:0]       i_mode;
  logic             o_busy;
  logic             o_valid;
  logic [CNT_W-1:0] o_candidate;

  modport master (
    output i_en, i_central, i_radius, i_mode,
    input  o_busy, o_valid, o_candidate
  );

  modport slave (
    input  i_en, i_central, i_radius, i_mode,
    output o_busy, o_valid, o_candidate
  );
endinterface

// File: rtl/set_count_gen.sv
// Counts grid points (1..GRID)^2 lying in a set built from two discs A and B,
// scanning one point per clock and reporting the count with a one-cycle strobe.
module set_count_gen #(
  parameter int CW    = 4,
  parameter int GRID  = 8,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  set_count_gen_if.slave bus
);

  if ((GRID > (2**CW) - 1) || ((2**CNT_W) <= GRID * GRID)) begin : g_param_check
    $error("set_count_gen: illegal CW/GRID/CNT_W combination");
  end

  localparam logic [CW-1:0] LP_GRID = CW'(GRID);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CW-1:0]    r_xa, r_ya, r_xb, r_yb, r_ra, r_rb;
  logic [1:0]       r_mode;
  logic [CW-1:0]    r_x, r_y;
  logic             r_hit;
  logic             r_pt_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [CNT_W-1:0] r_cand;

  logic             w_in_a, w_in_b, w_sel, w_last_pt;

  function automatic logic in_circle(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                     input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                     input logic [CW-1:0] r);
    logic [CW-1:0]   dx, dy;
    logic [2*CW+1:0] dxw, dyw, rw;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dxw = {{(CW+2){1'b0}}, dx};
    dyw = {{(CW+2){1'b0}}, dy};
    rw  = {{(CW+2){1'b0}}, r};
    return (dxw * dxw + dyw * dyw) <= (rw * rw);
  endfunction

  always_comb begin
    w_next    = r_state;
    w_in_a    = in_circle(r_x, r_y, r_xa, r_ya, r_ra);
    w_in_b    = in_circle(r_x, r_y, r_xb, r_yb, r_rb);
    w_last_pt = (r_x == LP_GRID) && (r_y == LP_GRID);
    w_sel     = 1'b0;
    case (r_mode)
      2'b00:   w_sel = w_in_a;
      2'b01:   w_sel = w_in_a & w_in_b;
      2'b10:   w_sel = w_in_a ^ w_in_b;
      default: w_sel = w_in_a | w_in_b;
    endcase
    case (r_state)
      IDLE:    if (bus.i_en) w_next = SCAN;
      SCAN:    if (r_pt_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Membership is registered into r_hit and accumulated a cycle later, so SCAN
  // runs GRID*GRID+1 cycles and the final count folds in the last pending hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_xa      <= '0;
      r_ya      <= '0;
      r_xb      <= '0;
      r_yb      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_mode    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_hit     <= 1'b0;
      r_pt_done <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_cand    <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_en) begin
            {r_xa, r_ya, r_xb, r_yb} <= bus.i_central;
            {r_ra, r_rb}             <= bus.i_radius;
            r_mode    <= bus.i_mode;
            r_x       <= LP_ONE;
            r_y       <= LP_ONE;
            r_hit     <= 1'b0;
            r_pt_done <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        SCAN: begin
          r_cnt <= r_cnt + CNT_W'(r_hit);
          if (r_pt_done) begin
            r_hit   <= 1'b0;
            r_cand  <= r_cnt + CNT_W'(r_hit);
            r_valid <= 1'b1;
          end else begin
            r_hit     <= w_sel;
            r_pt_done <= w_last_pt;
            if (r_y == LP_GRID) begin
              r_y <= LP_ONE;
              r_x <= r_x + LP_ONE;
            end else begin
              r_y <= r_y + LP_ONE;
            end
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_valid     = r_valid;
  assign bus.o_candidate = r_cand;

endmodule
